// File: rtl/fb_wr_pkg.sv
// Shared types and helpers for the frame-buffer write controller.
// Covers the FSM states, the buffer index type and the triple-buffer rotation rule.
package fb_wr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        ROTATE
    } state_t;

    typedef logic [1:0] buf_idx_t;

    localparam int NUM_BUF = 3;

    // Pick the one buffer that is neither being written nor displayed. If the reader
    // sits on the write buffer (or reports an illegal index) just step forward.
    function automatic buf_idx_t next_buf(input buf_idx_t wr, input buf_idx_t rd);
        buf_idx_t nb;
        if (rd == wr || rd >= buf_idx_t'(NUM_BUF))
            nb = (wr == buf_idx_t'(NUM_BUF - 1)) ? buf_idx_t'(0) : wr + buf_idx_t'(1);
        else
            nb = buf_idx_t'(3) - wr - rd;
        return nb;
    endfunction

endpackage

// File: rtl/fb_wr_ctrl_fifo.sv
// First-word-fall-through synchronous FIFO: the head word is on o_data whenever
// o_level is non-zero. Pushes when full and pops when empty are ignored.
module fb_sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 256
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    output logic [W-1:0]           o_data,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_level;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign w_full  = (r_level == FULL_LVL);
    assign w_empty = (r_level == '0);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !w_empty;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            r_level <= r_level + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge sys_clk) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rp];
    assign o_level = r_level;

endmodule

// File: rtl/fb_wr_ctrl.sv
// Frame-buffer write controller: buffers packed words, issues one memory burst at a
// time, flushes the partial burst at each frame start and rotates three buffers.
module fb_wr_ctrl
    import fb_wr_pkg::*;
#(
    parameter int                ADDR_W       = 28,
    parameter int                BURST_LEN    = 64,
    parameter int                FIFO_DEPTH   = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter logic [ADDR_W-1:0] FRAME_STRIDE = 28'h020_0000
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              frame_start_i,
    input  logic              wr_en_i,
    input  logic [31:0]       wr_d_i,
    output logic              mem_req_o,
    input  logic              mem_ack_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_len_o,
    input  logic              mem_rd_i,
    output logic [31:0]       mem_d_o,
    input  logic              mem_done_i,
    input  logic [1:0]        rd_buf_i,
    output logic [1:0]        wr_buf_o,
    output logic [1:0]        last_buf_o,
    output logic              frame_valid_o,
    output logic              frame_done_o,
    output logic              ovf_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BURST_CW = CW'(BURST_LEN);
    localparam logic [7:0]    BURST_L8 = 8'(BURST_LEN);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_unassigned;
    logic [CW-1:0]     r_residual;
    logic [ADDR_W-1:0] r_offset;
    logic [7:0]        r_len;
    logic [7:0]        w_len_nxt;
    logic              r_flush_pend;
    logic              r_words_seen;
    buf_idx_t          r_wr_buf;
    buf_idx_t          r_last_buf;
    logic              r_frame_valid;
    logic              r_frame_done;
    logic              r_ovf;

    logic [CW-1:0]     w_level;
    logic              w_full;
    logic              w_empty;
    logic              w_acc;
    logic              w_ack;
    logic              w_fs_take;
    logic              w_rotate;
    logic [CW-1:0]     w_ack_len;
    logic [ADDR_W:0]   w_off_sum;
    logic              w_wrap;
    logic [ADDR_W-1:0] w_off_nxt;
    logic [ADDR_W-1:0] w_buf_base;

    fb_sync_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .i_push  (wr_en_i),
        .i_data  (wr_d_i),
        .i_pop   (mem_rd_i),
        .o_data  (mem_d_o),
        .o_level (w_level)
    );

    assign w_full    = (w_level == FULL_LVL);
    assign w_empty   = (w_level == '0);
    assign w_acc     = wr_en_i && !w_full;
    assign w_ack     = (r_state == REQ) && mem_ack_i;
    assign w_fs_take = frame_start_i && !r_flush_pend;
    assign w_rotate  = (r_state == ROTATE);
    assign w_ack_len = w_ack ? CW'(r_len) : '0;

    assign w_off_sum = {1'b0, r_offset} + (ADDR_W + 1)'(r_len);
    assign w_wrap    = (w_off_sum >= {1'b0, FRAME_STRIDE});
    assign w_off_nxt = w_wrap ? ADDR_W'(w_off_sum - {1'b0, FRAME_STRIDE})
                              : w_off_sum[ADDR_W-1:0];

    always_comb begin
        w_buf_base = '0;
        case (r_wr_buf)
            2'd1:    w_buf_base = FRAME_STRIDE;
            2'd2:    w_buf_base = {FRAME_STRIDE[ADDR_W-2:0], 1'b0};
            default: w_buf_base = '0;
        endcase
    end

    assign mem_addr_o    = BASE_ADDR + w_buf_base + r_offset;
    assign mem_len_o     = r_len;
    assign mem_req_o     = (r_state == REQ);
    assign wr_buf_o      = r_wr_buf;
    assign last_buf_o    = r_last_buf;
    assign frame_valid_o = r_frame_valid;
    assign frame_done_o  = r_frame_done;
    assign ovf_o         = r_ovf;

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        unique case (r_state)
            IDLE: begin
                if (r_flush_pend && r_residual != '0) begin
                    w_len_nxt   = (r_residual >= BURST_CW) ? BURST_L8 : 8'(r_residual);
                    w_state_nxt = REQ;
                end else if (r_flush_pend) begin
                    w_state_nxt = ROTATE;
                end else if (r_unassigned >= BURST_CW) begin
                    w_len_nxt   = BURST_L8;
                    w_state_nxt = REQ;
                end
            end
            REQ:     if (mem_ack_i) w_state_nxt = XFER;
            XFER:    if (mem_done_i) w_state_nxt = IDLE;
            ROTATE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_len        <= '0;
            r_unassigned <= '0;
            r_residual   <= '0;
            r_offset     <= '0;
            r_flush_pend <= 1'b0;
            r_words_seen <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_len        <= w_len_nxt;
            r_unassigned <= r_unassigned + CW'(w_acc) - w_ack_len;

            // A burst acknowledged in the frame-start cycle already left the backlog.
            if (w_fs_take)
                r_residual <= r_unassigned - w_ack_len;
            else if (w_ack && r_flush_pend)
                r_residual <= r_residual - CW'(r_len);

            if (w_rotate)
                r_offset <= '0;
            else if (w_ack)
                r_offset <= w_off_nxt;

            if (w_fs_take)
                r_flush_pend <= r_words_seen;
            else if (w_rotate)
                r_flush_pend <= 1'b0;

            // A write alongside the pulse opens the new frame rather than the old one.
            if (w_fs_take)
                r_words_seen <= w_acc;
            else if (w_acc)
                r_words_seen <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_buf      <= '0;
            r_last_buf    <= '0;
            r_frame_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_ovf         <= 1'b0;
        end else begin
            r_frame_done <= w_rotate;
            if (w_rotate) begin
                r_last_buf    <= r_wr_buf;
                r_wr_buf      <= next_buf(r_wr_buf, rd_buf_i);
                r_frame_valid <= 1'b1;
            end
            if ((wr_en_i && w_full) || (mem_rd_i && w_empty) ||
                (frame_start_i && r_flush_pend) || (w_ack && w_wrap))
                r_ovf <= 1'b1;
        end
    end

endmodule

// File: doc/fb_wr_ctrl.md
# fb_wr_ctrl

Frame-buffer write controller that sits between the 24-to-32-bit pixel packer and the memory-controller write port. It buffers packed 32-bit words in a first-word-fall-through (FWFT) FIFO and issues fixed-length write bursts to memory, one burst outstanding at a time. It flushes the residual partial burst at each frame boundary and rotates three frame buffers (triple buffering) so the display reader never reads the buffer being written.

## Interface
Parameters:
- ADDR_W, 28: memory word-address width (32-bit words).
- BURST_LEN, 64: words per full burst; power of two, ≤ 255.
- FIFO_DEPTH, 256: FIFO entries; power of two, ≥ 2·BURST_LEN.
- BASE_ADDR, 0: word address of buffer 0.
- FRAME_STRIDE, 28'h020_0000: word-address distance between buffers.

Ports:
- sys_clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- frame_start_i  in  1  one-cycle pulse marking the start of a frame, driven during blanking.
- wr_en_i  in  1  packed word valid.
- wr_d_i  in  32  packed word.
- mem_req_o  out  1  burst request.
- mem_ack_i  in  1  request accepted.
- mem_addr_o  out  ADDR_W  burst start word address.
- mem_len_o  out  8  burst length in words, 1..BURST_LEN.
- mem_rd_i  in  1  memory controller pops one word.
- mem_d_o  out  32  FIFO head word, valid while the FIFO is non-empty.
- mem_done_i  in  1  one-cycle pulse: burst complete.
- rd_buf_i  in  2  buffer index currently being displayed (0..2).
- wr_buf_o  out  2  buffer index being written.
- last_buf_o  out  2  most recently completed buffer.
- frame_valid_o  out  1  at least one frame has completed.
- frame_done_o  out  1  one-cycle pulse on buffer rotation.
- ovf_o  out  1  sticky error flag.

## Operation
- **Counters**
  - `unassigned`: words in the FIFO not yet covered by an issued burst. It is incremented on every accepted write and decremented by `mem_len_o` on the request/acknowledge cycle.
  - `offset`: word offset inside the current buffer. It advances by `mem_len_o` on acknowledge. It wraps modulo FRAME_STRIDE; a wrap sets `ovf_o`.
- **Burst address:** `mem_addr_o` = BASE_ADDR + `wr_buf_o`·FRAME_STRIDE + `offset`.
- **FIFO full:** a write arriving while the FIFO is full is dropped, `ovf_o` is set, and `unassigned` is not incremented.
- **Frame boundary:** when `frame_start_i` pulses, `residual` ← `unassigned`. A write in the same cycle as the pulse belongs to the new frame. `flush_pend` is set only if at least one word was accepted since the last rotation. A `frame_start_i` that arrives while `flush_pend` is still set sets `ovf_o` and is otherwise ignored.
- **State machine:**
  - IDLE:
    - If `flush_pend` and `residual` > 0: load len = min(`residual`, BURST_LEN), go to REQ.
    - Else if `flush_pend` and `residual` = 0: go to ROTATE.
    - Else if `unassigned` ≥ BURST_LEN: load len = BURST_LEN, go to REQ.
  - REQ: `mem_req_o` = 1. Address and length are held stable until `mem_ack_i`. On acknowledge, go to XFER and decrement `residual` by len while flushing.
  - XFER: wait for `mem_done_i`, then go to IDLE.
  - ROTATE: one cycle.
    - `last_buf_o` ← `wr_buf_o`; `frame_valid_o` ← 1; `frame_done_o` pulses.
    - `offset` ← 0; `flush_pend` ← 0.
    - `wr_buf_o` ← 3 − `wr_buf_o` − `rd_buf_i`. If `rd_buf_i` = `wr_buf_o`, use (`wr_buf_o`+1) mod 3 instead.
- **Memory-controller contract:** `mem_rd_i` is asserted exactly len times, and only in XFER. A `mem_rd_i` while the FIFO is empty sets `ovf_o` and does not pop.
- **Reset values:** all outputs 0; `wr_buf_o` = 0, `last_buf_o` = 0; state IDLE; all counters 0; FIFO emptied. Asserting reset mid-burst aborts the burst immediately, with no flush.

## Timing
- The FIFO is FWFT: a word accepted in cycle t appears on `mem_d_o` at t+1 if the FIFO was empty.
- The write that brings `unassigned` to BURST_LEN in cycle t produces `mem_req_o` = 1 at t+2 (one cycle to update the count, one for the registered request).
- `mem_req_o` drops in the cycle after `mem_ack_i`.
- A pop at cycle t presents the next word at t+1.
- ROTATE completes one cycle after the last flush `mem_done_i` returns the state machine to IDLE.
- Writes are accepted in every cycle, including during a flush and during ROTATE.

## Structure
- Package `fb_wr_pkg`: state enum (IDLE, REQ, XFER, ROTATE), buffer-index type (2 bits), constant NUM_BUF = 3, function `next_buf(wr, rd)`.
- Sub-module `fb_sync_fifo`: parameterised FWFT synchronous FIFO with `level` output. `fb_wr_ctrl` contains only the counters, the state machine and the buffer-rotation logic.

## Test plan
- **Full bursts:** 128 consecutive writes, memory acknowledges after 3 cycles. Two requests with len 64 at addresses 0x0000000 and 0x0000040; data returned in order.
- **Partial flush:** 100 writes, then `frame_start_i`. One burst of len 64, then a flush burst of len 36 at 0x0000040. `frame_done_o` pulses; `last_buf_o` = 0, `wr_buf_o` = 2 with `rd_buf_i` = 1.
- **Rotation:** `rd_buf_i` = 0 with `wr_buf_o` = 1 at `frame_start_i` gives `wr_buf_o` = 2. The next frame's first burst address is 0x0400000.
- **Overflow:** memory never acknowledges; 257 writes. `ovf_o` = 1 after the 257th, FIFO level stays at 256, and `mem_req_o` is held high with address stable.
- **Empty frame:** `frame_start_i` immediately after reset produces no `frame_done_o` and `frame_valid_o` stays 0. A second `frame_start_i` while a flush is pending sets `ovf_o`.
- **Reset mid-burst:** `rst_n` low during XFER. All outputs return to reset values within the same cycle, and the FIFO is empty afterwards.
